// File: rtl/carry_select_adder8_if.sv
// Operand/result bundle for carry_select_adder8.
// OVF is present only when CSA8_OVF_EN is defined.
interface carry_select_adder8_if;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
`ifdef CSA8_OVF_EN
  logic       OVF;

  modport master (output A, output B, output Cin, input S, input Cout, input OVF);
  modport slave  (input A, input B, input Cin, output S, output Cout, output OVF);
`else
  modport master (output A, output B, output Cin, input S, input Cout);
  modport slave  (input A, input B, input Cin, output S, output Cout);
`endif
endinterface

// File: rtl/carry_select_adder8.sv
// Registered 8-bit carry-select adder: ripple low nibble selects a precomputed high nibble.
// Define CSA8_OVF_EN to add the registered signed-overflow output OVF.
module carry_select_adder8 (
  input logic                 clk,
  input logic                 rst,
  carry_select_adder8_if.slave bus
);

  // Returns {carry_out, sum[3:0]} of a 4-bit ripple of full adders.
  function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[4], s};
  endfunction

  logic [4:0] lo_res;
  logic [4:0] hi0_res;
  logic [4:0] hi1_res;
  logic [3:0] s_lo;
  logic [3:0] s_hi;
  logic       c4;
  logic       c8;

  always_comb begin
    lo_res  = rca4(bus.A[3:0], bus.B[3:0], bus.Cin);
    hi0_res = rca4(bus.A[7:4], bus.B[7:4], 1'b0);
    hi1_res = rca4(bus.A[7:4], bus.B[7:4], 1'b1);
    s_lo    = lo_res[3:0];
    c4      = lo_res[4];
    s_hi    = c4 ? hi1_res[3:0] : hi0_res[3:0];
    c8      = c4 ? hi1_res[4]   : hi0_res[4];
  end

  logic [7:0] s_q;
  logic       cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 8'h00;
      cout_q <= 1'b0;
    end else begin
      s_q    <= {s_hi, s_lo};
      cout_q <= c8;
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;

`ifdef CSA8_OVF_EN
  logic ovf;
  logic ovf_q;

  assign ovf = (bus.A[7] == bus.B[7]) && (s_hi[3] != bus.A[7]);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf;
  end

  assign bus.OVF = ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_adder8.sv
// Self-checking bench for carry_select_adder8: directed vectors, streaming, resets and random.
// Honours CSA8_OVF_EN for the OVF checks.
module tb_carry_select_adder8;

  logic clk;
  logic rst;

  carry_select_adder8_if bus ();

  carry_select_adder8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected result of the most recently applied operand set.
  logic       have_prev = 1'b0;
  logic [8:0] exp_sum;
  logic       exp_ovf;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain 9-bit unsigned sum and signed-range overflow.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c);
    int unsigned u;
    int          sv;
    u  = int'(a) + int'(b) + int'(c);
    sv = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {(sv > 127 || sv < -128), u[8:0]};
  endfunction

  task automatic check_prev(input string tag);
    if (have_prev) begin
      check({tag, ".sum"}, {bus.Cout, bus.S}, exp_sum);
`ifdef CSA8_OVF_EN
      check({tag, ".ovf"}, {8'h00, bus.OVF}, {8'h00, exp_ovf});
`endif
    end
  endtask

  // On each falling edge: check the previous result, then drive the next operands.
  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic r, input logic [8:0] esum,
                       input logic eovf);
    @(negedge clk);
    check_prev(tag);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = c;
    rst     = r;
    exp_sum = r ? 9'h000 : esum;
    exp_ovf = r ? 1'b0 : eovf;
    have_prev = 1'b1;
  endtask

  task automatic apply_model(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic r);
    logic [9:0] m;
    m = model(a, b, c);
    apply(tag, a, b, c, r, m[8:0], m[9]);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] sum;
    logic       ovf;
  } vec_t;

  vec_t dir[7] = '{
    '{8'h3E, 8'h7F, 1'b1, 9'h0BE, 1'b1},
    '{8'hAD, 8'hD5, 1'b1, 9'h183, 1'b0},
    '{8'h25, 8'hC1, 1'b1, 9'h0E7, 1'b0},
    '{8'h0C, 8'hEA, 1'b1, 9'h0F7, 1'b0},
    '{8'h0F, 8'h00, 1'b1, 9'h010, 1'b0},
    '{8'hF0, 8'h0F, 1'b0, 9'h0FF, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0}
  };

  initial begin
    bus.A   = 8'hFF;
    bus.B   = 8'hFF;
    bus.Cin = 1'b1;
    rst     = 1'b1;

    // Reset held with all-ones operands, then released.
    apply("reset0", 8'hFF, 8'hFF, 1'b1, 1'b1, 9'h000, 1'b0);
    apply("reset1", 8'hFF, 8'hFF, 1'b1, 1'b1, 9'h000, 1'b0);
    apply("reset2", 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0);

    // Directed vectors streamed back to back.
    foreach (dir[i])
      apply($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].c, 1'b0, dir[i].sum, dir[i].ovf);

    // One-cycle reset between two valid vectors.
    apply("midrst_pre", 8'h3E, 8'h7F, 1'b1, 1'b0, 9'h0BE, 1'b1);
    apply("midrst", 8'hAD, 8'hD5, 1'b1, 1'b1, 9'h000, 1'b0);
    apply("midrst_post", 8'h25, 8'hC1, 1'b1, 1'b0, 9'h0E7, 1'b0);

    // Every low-nibble/carry combination with random high nibbles.
    for (int i = 0; i < 512; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = {4'($urandom_range(15)), 4'(i[3:0])};
      b = {4'($urandom_range(15)), 4'(i[7:4])};
      apply_model("lo_sweep", a, b, i[8], 1'b0);
    end

    // Random operands with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      apply_model("rand", 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(63) == 0);
    end

    @(negedge clk);
    check_prev("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
